sdram_init_seq: RTL



---
 rtl/sdram_pkg.sv | 32 +++
 rtl/sdram_dly_cnt.sv | 35 +++
 rtl/sdram_init_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM init sequencer.
//   - command encodings {cs_n, ras_n, cas_n, we_n}
//   - init state enum (S_EMRS exists only when SDRAM_INIT_EMRS_EN is defined)
//   - sdram_clog2: ceiling log2 with a minimum result of 1, for counter widths
package sdram_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;   // EMRS shares this, selected by bank

    typedef enum logic [2:0] {
        S_WAIT,
        S_PRE,
        S_AR,
        S_MRS,
`ifdef SDRAM_INIT_EMRS_EN
        S_EMRS,
`endif
        S_DONE
    } init_state_e;

    function automatic int sdram_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sdram_dly_cnt.sv
// sdram_dly_cnt: loadable down-counter shared by every wait state of the
// init sequencer. Loading N makes 'zero' true N cycles later; it then holds
// at zero (no wrap).
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset (counter -> 0)
//   load in   load 'val' this cycle
//   val  in   W-bit load value
//   zero out  counter is zero
module sdram_dly_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)              cnt_d = val;
        else if (cnt_q != '0)  cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// sdram_init_seq: SDRAM power-up initialisation sequencer.
// Power-up wait, PRECHARGE ALL, AR_COUNT x AUTO REFRESH, MRS, optional EMRS
// (macro SDRAM_INIT_EMRS_EN), then init_done. A one-cycle init_req while
// done re-runs the sequence from PRECHARGE (power-up wait skipped).
// Ports:
//   sclk            in   clock, rising edge
//   rst             in   synchronous active-high reset
//   init_req        in   re-init request, honoured only while init_done=1
//   sdram_cke       out  clock enable (0 in reset and first wait cycle)
//   sdram_cs_n/ras_n/cas_n/we_n  out  registered command
//   sdram_bank      out  BANK_W bank address
//   sdram_addr      out  ADDR_W address
//   init_busy       out  sequence in progress
//   init_done       out  initialisation complete
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int                CLK_PERIOD_NS = 10,
    parameter int                T_POWERUP_NS  = 200_000,
    parameter int                T_RP_CLK      = 2,
    parameter int                T_RFC_CLK     = 7,
    parameter int                T_MRD_CLK     = 2,
    parameter int                AR_COUNT      = 8,
    parameter int                ADDR_W        = 12,
    parameter int                BANK_W        = 2,
    parameter int                CAS_LAT       = 3,
    parameter logic [2:0]        BL_CODE       = 3'b000,
    parameter logic [ADDR_W-1:0] EMRS_VAL      = '0
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              init_req,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              init_busy,
    output logic              init_done
);

    localparam int PWR_CYC = (T_POWERUP_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    localparam int MAX_A   = (PWR_CYC > T_RP_CLK) ? PWR_CYC : T_RP_CLK;
    localparam int MAX_B   = (T_RFC_CLK > T_MRD_CLK) ? T_RFC_CLK : T_MRD_CLK;
    localparam int MAX_DLY = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = sdram_clog2(MAX_DLY + 1);
    localparam int AR_W    = sdram_clog2(AR_COUNT + 1);

    // Loading T-1 on the command cycle puts the next command exactly T cycles later.
    localparam logic [CNT_W-1:0] LD_PWR = CNT_W'(PWR_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP_CLK - 1);
    localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC_CLK - 1);
    localparam logic [CNT_W-1:0] LD_MRD = CNT_W'(T_MRD_CLK - 1);
    localparam logic [AR_W-1:0]  AR_LAST = AR_W'(AR_COUNT);

    // Mode register: burst write, standard op, CAS latency, sequential, burst length.
    localparam logic [2:0]        CAS3     = 3'(CAS_LAT);
    localparam logic [9:0]        MRS10    = {1'b0, 2'b00, CAS3, 1'b0, BL_CODE};
    localparam logic [ADDR_W-1:0] MRS_ADDR = ADDR_W'(MRS10);
    localparam logic [ADDR_W-1:0] PRE_ADDR = ADDR_W'(11'h400);   // A10: all banks

    init_state_e       state_q, state_d;
    logic [AR_W-1:0]   ar_q, ar_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cke_q, cke_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dly_load;
    logic [CNT_W-1:0]  dly_val;
    logic              dly_zero;

    sdram_dly_cnt #(.W(CNT_W)) u_dly (
        .clk  (sclk),
        .rst  (rst),
        .load (dly_load),
        .val  (dly_val),
        .zero (dly_zero)
    );

    always_comb begin
        state_d  = state_q;
        ar_d     = ar_q;
        cmd_d    = CMD_NOP;
        bank_d   = '0;
        addr_d   = '0;
        // busy is first raised on cycle 0, so cke follows one cycle behind it
        cke_d    = cke_q | busy_q;
        busy_d   = busy_q;
        done_d   = done_q;
        dly_load = 1'b0;
        dly_val  = '0;
        case (state_q)
            S_WAIT: begin
                if (!busy_q) begin
                    // first cycle out of reset: start the power-up wait
                    busy_d   = 1'b1;
                    dly_load = 1'b1;
                    dly_val  = LD_PWR;
                end else if (dly_zero) begin
                    cmd_d    = CMD_PRE;
                    addr_d   = PRE_ADDR;
                    state_d  = S_PRE;
                    dly_load = 1'b1;
                    dly_val  = LD_RP;
                end
            end
            S_PRE: begin
                if (dly_zero) begin
                    cmd_d    = CMD_AREF;
                    ar_d     = ar_q + AR_W'(1);
                    state_d  = S_AR;
                    dly_load = 1'b1;
                    dly_val  = LD_RFC;
                end
            end
            S_AR: begin
                if (dly_zero) begin
                    dly_load = 1'b1;
                    if (ar_q == AR_LAST) begin
                        cmd_d   = CMD_MRS;
                        addr_d  = MRS_ADDR;
                        state_d = S_MRS;
                        dly_val = LD_MRD;
                    end else begin
                        cmd_d   = CMD_AREF;
                        ar_d    = ar_q + AR_W'(1);
                        dly_val = LD_RFC;
                    end
                end
            end
            S_MRS: begin
                if (dly_zero) begin
`ifdef SDRAM_INIT_EMRS_EN
                    cmd_d    = CMD_MRS;
                    bank_d   = BANK_W'(2);
                    addr_d   = EMRS_VAL;
                    state_d  = S_EMRS;
                    dly_load = 1'b1;
                    dly_val  = LD_MRD;
`else
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
`endif
                end
            end
`ifdef SDRAM_INIT_EMRS_EN
            S_EMRS: begin
                if (dly_zero) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            S_DONE: begin
                if (init_req) begin
                    cmd_d    = CMD_PRE;
                    addr_d   = PRE_ADDR;
                    ar_d     = '0;
                    state_d  = S_PRE;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    dly_load = 1'b1;
                    dly_val  = LD_RP;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q <= S_WAIT;
            ar_q    <= '0;
            cmd_q   <= CMD_NOP;
            bank_q  <= '0;
            addr_q  <= '0;
            cke_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            cmd_q   <= cmd_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            cke_q   <= cke_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
    assign sdram_cke  = cke_q;
    assign sdram_bank = bank_q;
    assign sdram_addr = addr_q;
    assign init_busy  = busy_q;
    assign init_done  = done_q;

endmodule
